// File: rtl/m_bcd_down_timer.sv
// Loadable multi-digit BCD countdown timer.
// Borrow ripples low digit to high; optional auto-reload on expiry.
module m_bcd_down_timer #(
    parameter int DIGITS      = 2,
    parameter int AUTO_RELOAD = 0
) (
    input  logic                clk,
    input  logic                n_reset,
    input  logic                tick,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                stop,
    output logic [4*DIGITS-1:0] bcd_out,
    output logic                running,
    output logic                expired,
    output logic                done
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        EXPIRED
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [W-1:0]   count_q;
    logic [W-1:0]   count_d;
    logic [W-1:0]   reload_q;
    logic [W-1:0]   reload_d;
    logic           done_q;
    logic           done_d;
    logic           cnt_zero;
    logic           cnt_one;
    logic           rld_zero;
    logic [W-1:0]   load_sat;
    logic [W-1:0]   count_dec;

    function automatic logic [W-1:0] bcd_sat(input logic [W-1:0] v);
        logic [W-1:0] r;
        r = v;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                r[4*i +: 4] = 4'd9;
            end
        end
        return r;
    endfunction

    // Borrow walks upward until a nonzero digit absorbs it.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        r      = v;
        borrow = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (borrow) begin
                if (v[4*i +: 4] == 4'd0) begin
                    r[4*i +: 4] = 4'd9;
                end else begin
                    r[4*i +: 4] = v[4*i +: 4] - 4'd1;
                    borrow      = 1'b0;
                end
            end
        end
        return r;
    endfunction

    assign load_sat  = bcd_sat(load_val);
    assign count_dec = bcd_dec(count_q);
    assign cnt_zero  = (count_q == '0);
    assign cnt_one   = (count_q == W'(1));
    assign rld_zero  = (reload_q == '0);

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q  <= IDLE;
            count_q  <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            done_q   <= done_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        done_d   = 1'b0;
        if (load) begin
            count_d  = load_sat;
            reload_d = load_sat;
            state_d  = IDLE;
        end else begin
            unique case (state_q)
                IDLE, PAUSE: begin
                    if (start && !stop && !cnt_zero) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (stop) begin
                        state_d = PAUSE;
                    end else if (tick && !cnt_zero) begin
                        if (cnt_one) begin
                            done_d = 1'b1;
                            if (AUTO_RELOAD != 0 && !rld_zero) begin
                                count_d = reload_q;
                            end else begin
                                count_d = '0;
                                state_d = EXPIRED;
                            end
                        end else begin
                            count_d = count_dec;
                        end
                    end
                end
                EXPIRED: begin
                    count_d = '0;
                end
            endcase
        end
    end

    assign bcd_out = count_q;
    assign running = (state_q == RUN);
    assign expired = (state_q == EXPIRED);
    assign done    = done_q;

endmodule
